player_move_ctrl: RTL and testbench

- Upstream stage of the CatTrap game engine; sits between the debouncers and switch inputs on one side and the game engine (`project`) on the other.
- Captures the player's Row/Col switch selection on a debounced place pulse and validates it.
- Tracks the blocked-cell bitmap and issues one move request to the engine over a valid/ready handshake.
- Reports an error code and move count for the SSD.

---
 rtl/cattrap_pkg.sv | 28 ++
 rtl/player_move_ctrl_onehot_enc.sv | 30 +++
 rtl/player_move_ctrl.sv | 134 +++++++++++++
 tb/tb_player_move_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cattrap_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : cattrap_pkg
// Description : Shared board geometry, move-controller state encoding and
//               placement error codes for the CatTrap front end.
// Revision    : 1.0 - initial release
// ============================================================================
package cattrap_pkg;

  localparam int BOARD_N = 8;
  localparam int IDX_W   = $clog2(BOARD_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_ROW     = 3'd1;
  localparam logic [2:0] ERR_COL     = 3'd2;
  localparam logic [2:0] ERR_BLOCKED = 3'd3;
  localparam logic [2:0] ERR_CAT     = 3'd4;
  localparam logic [2:0] ERR_OVER    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/player_move_ctrl_onehot_enc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onehot_enc
// Description : One-hot to binary encoder. valid is high only when exactly
//               one input bit is set; idx is meaningless otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_enc #(
  parameter int BOARD_N = cattrap_pkg::BOARD_N,
  parameter int IDX_W   = $clog2(BOARD_N)
) (
  input  logic [BOARD_N-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // OR together the positions of all set bits; exact for one-hot input
  always_comb begin
    idx = '0;
    for (int i = 0; i < BOARD_N; i++) begin
      if (vec[i]) idx = idx | IDX_W'(i);
    end
  end

  // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit
  assign valid = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule
`default_nettype wire

// File: rtl/player_move_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : player_move_ctrl
// Description : Captures a Row/Col switch selection on a place pulse,
//               validates it against the board state, records the blocked
//               cell and hands one move to the game engine (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module player_move_ctrl #(
  parameter int BOARD_N = cattrap_pkg::BOARD_N,
  parameter int IDX_W   = cattrap_pkg::IDX_W,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       Reset_n,
  input  logic [BOARD_N-1:0]         Row,
  input  logic [BOARD_N-1:0]         Col,
  input  logic                       place_pulse,
  input  logic                       new_game_pulse,
  input  logic [IDX_W-1:0]           cat_row,
  input  logic [IDX_W-1:0]           cat_col,
  input  logic                       game_over,
  input  logic                       move_ready,
  output logic                       move_valid,
  output logic [IDX_W-1:0]           move_row,
  output logic [IDX_W-1:0]           move_col,
  output logic [BOARD_N*BOARD_N-1:0] blocked,
  output logic [2:0]                 err_code,
  output logic [CNT_W-1:0]           move_count
);

  import cattrap_pkg::state_t;
  import cattrap_pkg::IDLE;
  import cattrap_pkg::CHECK;
  import cattrap_pkg::ISSUE;
  import cattrap_pkg::ERR_OK;
  import cattrap_pkg::ERR_ROW;
  import cattrap_pkg::ERR_COL;
  import cattrap_pkg::ERR_BLOCKED;
  import cattrap_pkg::ERR_CAT;
  import cattrap_pkg::ERR_OVER;

  localparam int CELL_W = $clog2(BOARD_N * BOARD_N);

  state_t               r_state;
  logic [BOARD_N-1:0]   r_row;
  logic [BOARD_N-1:0]   r_col;

  logic [IDX_W-1:0]     w_row_idx;
  logic [IDX_W-1:0]     w_col_idx;
  logic                 w_row_ok;
  logic                 w_col_ok;
  logic [CELL_W-1:0]    w_cell;
  logic [2:0]           w_err;

  onehot_enc #(.BOARD_N(BOARD_N), .IDX_W(IDX_W)) u_row_enc (
    .vec   (r_row),
    .idx   (w_row_idx),
    .valid (w_row_ok)
  );

  onehot_enc #(.BOARD_N(BOARD_N), .IDX_W(IDX_W)) u_col_enc (
    .vec   (r_col),
    .idx   (w_col_idx),
    .valid (w_col_ok)
  );

  assign w_cell = CELL_W'(int'(w_row_idx) * BOARD_N + int'(w_col_idx));

  // First-match error priority; the encoded indices are only consulted once
  // both selections are known to be one-hot
  always_comb begin
    w_err = ERR_OK;
    if (game_over)                                         w_err = ERR_OVER;
    else if (!w_row_ok)                                    w_err = ERR_ROW;
    else if (!w_col_ok)                                    w_err = ERR_COL;
    else if (blocked[w_cell])                              w_err = ERR_BLOCKED;
    else if ((w_row_idx == cat_row) && (w_col_idx == cat_col)) w_err = ERR_CAT;
  end

  // Capture -> check -> issue sequencer; new game overrides everything
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      move_valid <= 1'b0;
      move_row   <= '0;
      move_col   <= '0;
      blocked    <= '0;
      err_code   <= ERR_OK;
      move_count <= '0;
    end else if (new_game_pulse) begin
      r_state    <= IDLE;
      move_valid <= 1'b0;
      blocked    <= '0;
      err_code   <= ERR_OK;
      move_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (place_pulse) begin
            r_row   <= Row;
            r_col   <= Col;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          err_code <= w_err;
          if (w_err == ERR_OK) begin
            blocked[w_cell] <= 1'b1;
            if (move_count != {CNT_W{1'b1}}) move_count <= move_count + 1'b1;
            move_row   <= w_row_idx;
            move_col   <= w_col_idx;
            move_valid <= 1'b1;
            r_state    <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_move_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_player_move_ctrl
// Description : Self-checking bench for player_move_ctrl (8x8 and 16x16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_move_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int BN = 16;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset_n;
  logic [N-1:0]  Row, Col;
  logic          place_pulse, new_game_pulse, game_over, move_ready;
  logic [IW-1:0] cat_row, cat_col;
  logic          move_valid;
  logic [IW-1:0] move_row, move_col;
  logic [N*N-1:0] blocked;
  logic [2:0]    err_code;
  logic [7:0]    move_count;

  logic [BN-1:0]    b_row, b_col;
  logic             b_place;
  logic [BW-1:0]    b_cat_row, b_cat_col;
  logic             b_move_valid;
  logic [BW-1:0]    b_move_row, b_move_col;
  logic [BN*BN-1:0] b_blocked;
  logic [2:0]       b_err_code;
  logic [7:0]       b_move_count;

  player_move_ctrl #(.BOARD_N(N), .IDX_W(IW), .CNT_W(8)) dut (
    .clk(clk), .Reset_n(Reset_n), .Row(Row), .Col(Col),
    .place_pulse(place_pulse), .new_game_pulse(new_game_pulse),
    .cat_row(cat_row), .cat_col(cat_col), .game_over(game_over),
    .move_ready(move_ready), .move_valid(move_valid), .move_row(move_row),
    .move_col(move_col), .blocked(blocked), .err_code(err_code),
    .move_count(move_count)
  );

  player_move_ctrl #(.BOARD_N(BN), .IDX_W(BW), .CNT_W(8)) dut_big (
    .clk(clk), .Reset_n(Reset_n), .Row(b_row), .Col(b_col),
    .place_pulse(b_place), .new_game_pulse(1'b0),
    .cat_row(b_cat_row), .cat_col(b_cat_col), .game_over(1'b0),
    .move_ready(1'b1), .move_valid(b_move_valid), .move_row(b_move_row),
    .move_col(b_move_col), .blocked(b_blocked), .err_code(b_err_code),
    .move_count(b_move_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference board: which cells are taken, how many moves, last result
  bit [N*N-1:0] m_blk;
  int           m_cnt;
  int           m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input logic [N-1:0] v);
    int p = 0;
    for (int i = 0; i < N; i++) if (v[i]) p = i;
    return p;
  endfunction

  function automatic int ref_err(input logic [N-1:0] r, input logic [N-1:0] c,
                                 input int cr, input int cc, input bit go);
    if (go) return 5;
    if ($countones(r) != 1) return 1;
    if ($countones(c) != 1) return 2;
    if (m_blk[pos_of(r) * N + pos_of(c)]) return 3;
    if (pos_of(r) == cr && pos_of(c) == cc) return 4;
    return 0;
  endfunction

  task automatic model_clear();
    m_blk = '0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_err"},   64'(err_code),   64'(m_err));
    chk({tag, "_count"}, 64'(move_count), 64'(m_cnt));
    chk({tag, "_blk"},   64'(blocked),    64'(m_blk));
  endtask

  // one complete placement with move_ready tied high
  task automatic attempt(input string tag, input logic [N-1:0] r, input logic [N-1:0] c,
                         input int cr, input int cc, input bit go);
    int e;
    Row = r; Col = c; cat_row = IW'(cr); cat_col = IW'(cc);
    game_over = go; move_ready = 1'b1; place_pulse = 1'b1;
    tick();
    place_pulse = 1'b0;
    Row = N'($urandom); Col = N'($urandom);   // must not disturb the move in flight
    chk({tag, "_chk_valid"}, 64'(move_valid), 64'(0));
    e = ref_err(r, c, cr, cc, go);
    tick();
    m_err = e;
    if (e == 0) begin
      m_blk[pos_of(r) * N + pos_of(c)] = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    chk({tag, "_valid"}, 64'(move_valid), 64'(e == 0));
    if (e == 0) begin
      chk({tag, "_row"}, 64'(move_row), 64'(pos_of(r)));
      chk({tag, "_col"}, 64'(move_col), 64'(pos_of(c)));
    end
    chk_state(tag);
    tick();
    chk({tag, "_done_valid"}, 64'(move_valid), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] r, c;
    int e;
    Reset_n = 1'b0; Row = '0; Col = '0; place_pulse = 1'b0; new_game_pulse = 1'b0;
    cat_row = '0; cat_col = '0; game_over = 1'b0; move_ready = 1'b0;
    b_row = '0; b_col = '0; b_place = 1'b0; b_cat_row = '0; b_cat_col = '0;
    model_clear();

    // reset values
    tick(); tick();
    chk("rst_valid", 64'(move_valid), 64'(0));
    chk("rst_row",   64'(move_row),   64'(0));
    chk("rst_col",   64'(move_col),   64'(0));
    chk_state("rst");
    Reset_n = 1'b1;
    tick();

    // basic move, repeat cell, selection errors, cat and game-over precedence
    attempt("first",   8'h04, 8'h10, 0, 0, 1'b0);
    chk("first_bit20", 64'(blocked[20]), 64'(1));
    attempt("repeat",  8'h04, 8'h10, 0, 0, 1'b0);
    attempt("row_two", 8'h05, 8'h10, 0, 0, 1'b0);
    attempt("row_zero",8'h00, 8'h10, 0, 0, 1'b0);
    attempt("col_zero",8'h01, 8'h00, 0, 0, 1'b0);
    attempt("on_cat",  8'h08, 8'h08, 3, 3, 1'b0);
    attempt("over",    8'h08, 8'h08, 3, 3, 1'b1);

    // engine stalls 10 cycles; a second place pulse is dropped
    cat_row = '0; cat_col = '0; game_over = 1'b0; move_ready = 1'b0;
    Row = 8'h40; Col = 8'h02; place_pulse = 1'b1;
    e = ref_err(8'h40, 8'h02, 0, 0, 1'b0);
    tick(); place_pulse = 1'b0; tick();
    m_err = e;
    if (e == 0) begin m_blk[6*N+1] = 1'b1; m_cnt++; end
    chk("stall_valid0", 64'(move_valid), 64'(1));
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin Row = 8'h01; Col = 8'h01; place_pulse = 1'b1; end
      else place_pulse = 1'b0;
      tick();
      chk("stall_valid", 64'(move_valid), 64'(1));
      chk("stall_row",   64'(move_row),   64'(6));
      chk("stall_col",   64'(move_col),   64'(1));
    end
    place_pulse = 1'b0; move_ready = 1'b1;
    tick();
    chk("stall_release", 64'(move_valid), 64'(0));
    tick(); tick(); tick();
    chk("stall_noqueue", 64'(move_valid), 64'(0));
    chk_state("stall");

    // new game during ISSUE together with ready and a place pulse
    move_ready = 1'b0; Row = 8'h02; Col = 8'h02; place_pulse = 1'b1;
    tick(); place_pulse = 1'b0; tick();
    chk("ng_issue_valid", 64'(move_valid), 64'(1));
    new_game_pulse = 1'b1; move_ready = 1'b1; place_pulse = 1'b1;
    Row = 8'h04; Col = 8'h10;
    tick();
    new_game_pulse = 1'b0; place_pulse = 1'b0;
    model_clear();
    chk("ng_valid", 64'(move_valid), 64'(0));
    chk_state("ng");
    tick();
    chk("ng_pulse_dropped", 64'(move_valid), 64'(0));
    attempt("after_ng", 8'h04, 8'h10, 0, 0, 1'b0);

    // asynchronous reset while a move is pending
    move_ready = 1'b0; Row = 8'h80; Col = 8'h80; place_pulse = 1'b1;
    tick(); place_pulse = 1'b0; tick();
    chk("ar_valid_before", 64'(move_valid), 64'(1));
    #2 Reset_n = 1'b0;
    #1;
    model_clear();
    chk("ar_valid", 64'(move_valid), 64'(0));
    chk_state("ar");
    @(negedge clk) Reset_n = 1'b1;
    tick();

    // randomized placements against the reference board
    for (int t = 0; t < 40; t++) begin
      r = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(1 << $urandom_range(0, N-1));
      c = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(1 << $urandom_range(0, N-1));
      attempt("rand", r, c, int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)),
              $urandom_range(0, 9) == 0);
    end

    // 16x16 board: fill every cell, counter must stop at 255
    for (int i = 0; i < BN*BN; i++) begin
      b_row = BN'(1) << (i / BN);
      b_col = BN'(1) << (i % BN);
      b_cat_row = (i == 0) ? BW'(15) : BW'(0);
      b_cat_col = (i == 0) ? BW'(15) : BW'(0);
      b_place = 1'b1;
      tick(); b_place = 1'b0; tick(); tick();
      if (i == 127) chk("big_count_128", 64'(b_move_count), 64'(128));
      if (i == 254) chk("big_count_255", 64'(b_move_count), 64'(255));
    end
    chk("big_count_sat", 64'(b_move_count), 64'(255));
    chk("big_err",       64'(b_err_code),   64'(0));
    chk("big_full",      64'(&b_blocked),   64'(1));
    chk("big_valid",     64'(b_move_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
